uart_tx_buf: RTL and testbench

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_fifo.sv | 63 ++++++
 rtl/uart_tx_buf.sv | 160 ++++++++++++++++
 tb/tb_uart_tx_buf.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the buffered UART transmitter.
package uart_pkg;

    // Parity mode applied to every frame
    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_t;

    // Serialiser state
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read: dout is valid the cycle after pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_FULL);
    assign empty   = (count_reg == '0);
    // A push into a full buffer is dropped even when a pop frees a slot this cycle
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Storage array, kept free of reset so it maps onto RAM
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers (wrap naturally at power-of-two depth), occupancy and read register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            dout       <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                dout       <= mem[rd_ptr_reg];
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: FIFO of pending words feeding a framed serialiser.
// TX is registered from the current state, so the line trails the state by one
// clock; every bit therefore still lasts exactly BAUD_DIV clocks.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int      DATA_W     = 8,
    parameter int      BAUD_DIV   = 2604,
    parameter int      FIFO_DEPTH = 4,
    parameter parity_t PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              trmt,
    input  logic [DATA_W-1:0] tx_data,
    output logic              TX,
    output logic              tx_done,
    output logic              full,
    output logic              empty,
    output logic              ovf
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             PAR_INV   = (PARITY == PAR_ODD);

    tx_state_t         state_reg;
    logic [CNT_W-1:0]  baud_cnt_reg;
    logic [BIT_W-1:0]  bit_cnt_reg;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] fifo_dout;
    logic              par_reg;
    logic              finish_reg;
    logic              bit_end;
    logic              pop;

    assign bit_end = (baud_cnt_reg == BAUD_LAST);
    // Pop when idle, or at the end of the last stop bit to chain frames gap-free
    assign pop = !empty &&
                 ((state_reg == IDLE) ||
                  ((state_reg == STOP) && bit_end && (bit_cnt_reg == STOP_LAST)));

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (trmt),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    // Overflow pulse: a write strobe that found the buffer full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= trmt && full;
        end
    end

    // Frame sequencer with baud and bit counters; drives TX and tx_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            par_reg      <= 1'b0;
            finish_reg   <= 1'b0;
            TX           <= 1'b1;
            tx_done      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    TX         <= 1'b1;
                    finish_reg <= 1'b0;
                    if (finish_reg) begin
                        tx_done <= 1'b1;
                    end
                    if (!empty) begin
                        state_reg    <= START;
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                    end
                end
                START: begin
                    TX      <= 1'b0;
                    tx_done <= 1'b0;
                    // The popped word appears on fifo_dout one clock after the pop
                    if (baud_cnt_reg == '0) begin
                        shift_reg <= fifo_dout;
                        par_reg   <= (^fifo_dout) ^ PAR_INV;
                    end
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= DATA;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
                    end
                end
                DATA: begin
                    TX <= shift_reg[0];
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        shift_reg    <= shift_reg >> 1;
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_reg <= '0;
                            state_reg   <= (PARITY != PAR_NONE) ? PAR : STOP;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
                    end
                end
                PAR: begin
                    TX <= par_reg;
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        state_reg    <= STOP;
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
                    end
                end
                STOP: begin
                    TX <= 1'b1;
                    if (bit_end) begin
                        baud_cnt_reg <= '0;
                        if (bit_cnt_reg == STOP_LAST) begin
                            bit_cnt_reg <= '0;
                            if (!empty) begin
                                state_reg <= START;
                            end else begin
                                state_reg  <= IDLE;
                                finish_reg <= 1'b1;
                            end
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                        end
                    end else begin
                        baud_cnt_reg <= baud_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: four instances (8N1, 8E1, 8O1, 7N2) at 16 clocks/bit.
module tb_uart_tx_buf;
    import uart_pkg::*;

    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trmt_v  [4];
    logic [7:0] data_v  [4];
    logic       tx_v    [4];
    logic       done_v  [4];
    logic       full_v  [4];
    logic       empty_v [4];
    logic       ovf_v   [4];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_tx_buf #(.DATA_W(8), .BAUD_DIV(BD), .FIFO_DEPTH(4), .PARITY(PAR_NONE), .STOP_BITS(1)) u_n (
        .clk(clk), .rst_n(rst_n), .trmt(trmt_v[0]), .tx_data(data_v[0]),
        .TX(tx_v[0]), .tx_done(done_v[0]), .full(full_v[0]), .empty(empty_v[0]), .ovf(ovf_v[0]));

    uart_tx_buf #(.DATA_W(8), .BAUD_DIV(BD), .FIFO_DEPTH(4), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_e (
        .clk(clk), .rst_n(rst_n), .trmt(trmt_v[1]), .tx_data(data_v[1]),
        .TX(tx_v[1]), .tx_done(done_v[1]), .full(full_v[1]), .empty(empty_v[1]), .ovf(ovf_v[1]));

    uart_tx_buf #(.DATA_W(8), .BAUD_DIV(BD), .FIFO_DEPTH(4), .PARITY(PAR_ODD), .STOP_BITS(1)) u_o (
        .clk(clk), .rst_n(rst_n), .trmt(trmt_v[2]), .tx_data(data_v[2]),
        .TX(tx_v[2]), .tx_done(done_v[2]), .full(full_v[2]), .empty(empty_v[2]), .ovf(ovf_v[2]));

    uart_tx_buf #(.DATA_W(7), .BAUD_DIV(BD), .FIFO_DEPTH(4), .PARITY(PAR_NONE), .STOP_BITS(2)) u_7 (
        .clk(clk), .rst_n(rst_n), .trmt(trmt_v[3]), .tx_data(data_v[3][6:0]),
        .TX(tx_v[3]), .tx_done(done_v[3]), .full(full_v[3]), .empty(empty_v[3]), .ovf(ovf_v[3]));

    // Advance to 1 ns after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single write strobe into an idle instance, then check the two-edge start latency
    task automatic send(input int idx, input logic [7:0] d);
        data_v[idx] = d;
        trmt_v[idx] = 1'b1;
        step();
        trmt_v[idx] = 1'b0;
        data_v[idx] = ~d;
        step();
        total++;
        if (tx_v[idx] !== 1'b1) begin
            bad++;
            $display("FAIL latency_idle inst=%0d tx=%b expected 1", idx, tx_v[idx]);
        end
        step();
        total++;
        if (tx_v[idx] !== 1'b0) begin
            bad++;
            $display("FAIL latency_start inst=%0d tx=%b expected 0", idx, tx_v[idx]);
        end
    endtask

    // Called at the first clock of a start bit; bits[i] is the i-th bit on the wire.
    // Each bit must hold for BD clocks. Leaves time at the first clock after the frame.
    task automatic check_frame(input int idx, input string name, input logic [11:0] bits,
                               input int n, input logic done_exp);
        logic ok;
        logic seen;
        for (int b = 0; b < n; b++) begin
            ok   = 1'b1;
            seen = bits[b];
            for (int c = 0; c < BD; c++) begin
                if (b != 0 || c != 0) step();
                if (tx_v[idx] !== bits[b]) begin
                    ok   = 1'b0;
                    seen = tx_v[idx];
                end
            end
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL %s bit%0d tx=%b expected %b for %0d clocks", name, b, seen, bits[b], BD);
            end
        end
        total++;
        if (done_v[idx] !== 1'b0) begin
            bad++;
            $display("FAIL %s_done_early tx_done=%b expected 0", name, done_v[idx]);
        end
        step();
        if (done_exp) begin
            total++;
            if (done_v[idx] !== 1'b1 || tx_v[idx] !== 1'b1 || empty_v[idx] !== 1'b1) begin
                bad++;
                $display("FAIL %s_done tx_done=%b tx=%b empty=%b expected 1 1 1",
                         name, done_v[idx], tx_v[idx], empty_v[idx]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (tx_v[i] !== 1'b1 || done_v[i] !== 1'b0 || empty_v[i] !== 1'b1 ||
                full_v[i] !== 1'b0 || ovf_v[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset inst=%0d tx=%b done=%b empty=%b full=%b ovf=%b expected 1 0 1 0 0",
                         i, tx_v[i], done_v[i], empty_v[i], full_v[i], ovf_v[i]);
            end
        end
        rst_n = 1'b1;
        repeat (5) step();
        total++;
        if (tx_v[0] !== 1'b1 || empty_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_idle tx=%b empty=%b done=%b expected 1 1 0",
                     tx_v[0], empty_v[0], done_v[0]);
        end
    endtask

    task automatic test_8n1();
        send(0, 8'hAA);
        check_frame(0, "8n1_aa", {1'b1, 8'hAA, 1'b0}, 10, 1'b1);
    endtask

    // 0x69 has four set bits: even parity 0, odd parity 1
    task automatic test_parity();
        send(1, 8'h69);
        check_frame(1, "8e1_69", {1'b1, 1'b0, 8'h69, 1'b0}, 11, 1'b1);
        send(2, 8'h69);
        check_frame(2, "8o1_69", {1'b1, 1'b1, 8'h69, 1'b0}, 11, 1'b1);
    endtask

    task automatic test_7n2();
        send(3, 8'h41);
        check_frame(3, "7n2_41", {2'b11, 7'h41, 1'b0}, 10, 1'b1);
    endtask

    task automatic test_back_to_back();
        trmt_v[0] = 1'b1;
        data_v[0] = 8'hAA;
        step();
        data_v[0] = 8'h55;
        step();
        data_v[0] = 8'h69;
        step();
        trmt_v[0] = 1'b0;
        data_v[0] = 8'h00;
        total++;
        if (tx_v[0] !== 1'b0 || empty_v[0] !== 1'b0 || full_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL b2b_queue tx=%b empty=%b full=%b expected 0 0 0",
                     tx_v[0], empty_v[0], full_v[0]);
        end
        check_frame(0, "b2b_f1", {1'b1, 8'hAA, 1'b0}, 10, 1'b0);
        check_frame(0, "b2b_f2", {1'b1, 8'h55, 1'b0}, 10, 1'b0);
        check_frame(0, "b2b_f3", {1'b1, 8'h69, 1'b0}, 10, 1'b1);
    endtask

    task automatic test_overflow();
        logic ok;
        fork
            begin
                trmt_v[0] = 1'b1;
                data_v[0] = 8'h11;
                step();
                data_v[0] = 8'h22;
                step();
                data_v[0] = 8'h33;
                step();
                data_v[0] = 8'h44;
                step();
                total++;
                if (full_v[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_not_full_yet full=%b expected 0", full_v[0]);
                end
                data_v[0] = 8'h55;
                step();
                total++;
                if (full_v[0] !== 1'b1 || ovf_v[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_full_after_5 full=%b ovf=%b expected 1 0", full_v[0], ovf_v[0]);
                end
                data_v[0] = 8'h66;
                step();
                trmt_v[0] = 1'b0;
                data_v[0] = 8'h00;
                total++;
                if (ovf_v[0] !== 1'b1 || full_v[0] !== 1'b1) begin
                    bad++;
                    $display("FAIL ovf_pulse ovf=%b full=%b expected 1 1", ovf_v[0], full_v[0]);
                end
                step();
                total++;
                if (ovf_v[0] !== 1'b0) begin
                    bad++;
                    $display("FAIL ovf_one_cycle ovf=%b expected 0", ovf_v[0]);
                end
            end
            begin
                repeat (3) step();
                check_frame(0, "ovf_f1", {1'b1, 8'h11, 1'b0}, 10, 1'b0);
                check_frame(0, "ovf_f2", {1'b1, 8'h22, 1'b0}, 10, 1'b0);
                check_frame(0, "ovf_f3", {1'b1, 8'h33, 1'b0}, 10, 1'b0);
                check_frame(0, "ovf_f4", {1'b1, 8'h44, 1'b0}, 10, 1'b0);
                check_frame(0, "ovf_f5", {1'b1, 8'h55, 1'b0}, 10, 1'b1);
            end
        join
        ok = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (tx_v[0] !== 1'b1 || done_v[0] !== 1'b1) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL ovf_no_sixth_frame tx=%b done=%b expected line idle", tx_v[0], done_v[0]);
        end
    endtask

    task automatic test_reset_mid();
        logic ok;
        send(0, 8'h0F);
        // queue a second word so the flush is observable
        trmt_v[0] = 1'b1;
        data_v[0] = 8'hF0;
        step();
        trmt_v[0] = 1'b0;
        // into data bit 5 of 0x0F, which is a 0 on the line
        repeat (BD + 5 * BD + 6) step();
        total++;
        if (tx_v[0] !== 1'b0 || empty_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_pre_reset tx=%b empty=%b expected 0 0", tx_v[0], empty_v[0]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (tx_v[0] !== 1'b1 || empty_v[0] !== 1'b1 || done_v[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset tx=%b empty=%b done=%b expected 1 1 0",
                     tx_v[0], empty_v[0], done_v[0]);
        end
        step();
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 300; i++) begin
            step();
            if (tx_v[0] !== 1'b1 || empty_v[0] !== 1'b1) ok = 1'b0;
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL mid_no_resume tx=%b empty=%b expected 1 1", tx_v[0], empty_v[0]);
        end
        send(0, 8'h0F);
        check_frame(0, "mid_new_0f", {1'b1, 8'h0F, 1'b0}, 10, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            trmt_v[i] = 1'b0;
            data_v[i] = 8'h00;
        end
        test_reset();
        test_8n1();
        test_parity();
        test_7n2();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
